// File: rtl/flag_pkg.sv
// flag_pkg: shared types for the flag pattern arbiter.
// Holds the packed four-field flag word, the field index constants,
// the control FSM state type and the per-field update rule.
package flag_pkg;

  // Flag word; `first` lands in the MSB, `fourth` in the LSB.
  typedef struct packed {
    logic first;
    logic second;
    logic third;
    logic fourth;
  } struct_t;

  localparam int FIRST_IDX  = 3;
  localparam int SECOND_IDX = 2;
  localparam int THIRD_IDX  = 1;
  localparam int FOURTH_IDX = 0;
  localparam int NFIELDS    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  // One field of an assignment pattern: an explicitly named field takes its
  // value, otherwise the default fill (when enabled), otherwise it holds.
  function automatic logic field_update(
    input logic named,
    input logic value,
    input logic fill_en,
    input logic fill_val,
    input logic current
  );
    logic result;
    if (named) begin
      result = value;
    end else if (fill_en) begin
      result = fill_val;
    end else begin
      result = current;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request picker.
// The pointer remembers the last winner; the search starts one past it and
// wraps, so the most recent winner always has the lowest priority.
module rr_arbiter
  import flag_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] last_reg;

  // Scan from last+1 upward, modulo NREQ, and take the first active request.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IW'((int'(last_reg) + off) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Record the winner when the caller accepts the grant; reset makes
  // requester 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= IW'(NREQ - 1);
    end else if (advance) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/flag_pattern_arbiter.sv
// flag_pattern_arbiter: shares one registered four-field flag word between
// NREQ requesters. Each granted request applies a mask/value pattern, with an
// optional default fill for unnamed fields. Two cycles per update: IDLE picks
// and latches a winner, APPLY acknowledges it and writes the word.
// Optional feature macro: FLAG_PATTERN_DEFAULT_EN (default fill support).
module flag_pattern_arbiter
  import flag_pkg::*;
#(
  parameter int         NREQ        = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*4-1:0]       req_mask,
  input  logic [NREQ*4-1:0]       req_value,
  input  logic [NREQ-1:0]         req_default_en,
  input  logic [NREQ-1:0]         req_default_val,
  output logic [NREQ-1:0]         req_ready,
  output struct_t                 flags_o,
  output logic                    upd_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);

  genvar gi;

  state_t                state_reg;
  state_t                state_next;
  logic                  advance;
  logic [NREQ-1:0]       arb_grant;
  logic [IW-1:0]         arb_idx;
  logic [NREQ:0][3:0]    mask_chain;
  logic [NREQ:0][3:0]    value_chain;
  logic [3:0]            hold_mask_reg;
  logic [3:0]            hold_value_reg;
  logic [IW-1:0]         grant_id_reg;
  logic [3:0]            flags_reg;
  logic [3:0]            flags_next;
  logic                  upd_valid_reg;
  logic                  fill_en;
  logic                  fill_val;

  // A winner is taken only from IDLE; requests seen during APPLY wait.
  assign advance = (state_reg == IDLE) && (|req_valid);

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (advance),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  // AND-OR select of the winner's pattern using the one-hot grant.
  assign mask_chain[0]  = '0;
  assign value_chain[0] = '0;
  for (gi = 0; gi < NREQ; gi++) begin : g_sel
    assign mask_chain[gi+1]  = mask_chain[gi]  | (req_mask[gi*4 +: 4]  & {4{arb_grant[gi]}});
    assign value_chain[gi+1] = value_chain[gi] | (req_value[gi*4 +: 4] & {4{arb_grant[gi]}});
  end

`ifdef FLAG_PATTERN_DEFAULT_EN
  logic [NREQ:0] den_chain;
  logic [NREQ:0] dval_chain;
  logic          hold_def_en_reg;
  logic          hold_def_val_reg;

  assign den_chain[0]  = 1'b0;
  assign dval_chain[0] = 1'b0;
  for (gi = 0; gi < NREQ; gi++) begin : g_sel_def
    assign den_chain[gi+1]  = den_chain[gi]  | (req_default_en[gi]  & arb_grant[gi]);
    assign dval_chain[gi+1] = dval_chain[gi] | (req_default_val[gi] & arb_grant[gi]);
  end

  // Latch the winner's default-fill controls alongside its pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_def_en_reg  <= 1'b0;
      hold_def_val_reg <= 1'b0;
    end else if (advance) begin
      hold_def_en_reg  <= den_chain[NREQ];
      hold_def_val_reg <= dval_chain[NREQ];
    end
  end

  assign fill_en  = hold_def_en_reg;
  assign fill_val = hold_def_val_reg;
`else
  // Default fill is compiled out: unnamed fields always hold their value.
  logic unused_default;
  assign unused_default = ^{req_default_en, req_default_val};
  assign fill_en  = 1'b0;
  assign fill_val = 1'b0;
`endif

  // Next flag word from the held pattern, one field at a time.
  for (gi = 0; gi < NFIELDS; gi++) begin : g_field
    assign flags_next[gi] = field_update(hold_mask_reg[gi], hold_value_reg[gi],
                                         fill_en, fill_val, flags_reg[gi]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: IDLE waits for any request, APPLY always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_valid) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: acknowledge the latched winner during APPLY.
  always_comb begin
    req_ready = '0;
    if (state_reg == APPLY) begin
      req_ready = NREQ'(1) << grant_id_reg;
    end
  end

  // Latch the winner's pattern and index when it is picked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_mask_reg  <= '0;
      hold_value_reg <= '0;
      grant_id_reg   <= '0;
    end else if (advance) begin
      hold_mask_reg  <= mask_chain[NREQ];
      hold_value_reg <= value_chain[NREQ];
      grant_id_reg   <= arb_idx;
    end
  end

  // Write the flag word at the end of APPLY and pulse upd_valid with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg     <= RESET_FLAGS;
      upd_valid_reg <= 1'b0;
    end else begin
      upd_valid_reg <= 1'b0;
      if (state_reg == APPLY) begin
        flags_reg     <= flags_next;
        upd_valid_reg <= 1'b1;
      end
    end
  end

  assign flags_o   = struct_t'(flags_reg);
  assign upd_valid = upd_valid_reg;
  assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_flag_pattern_arbiter.sv
// tb_flag_pattern_arbiter: table vectors, directed multi-cycle sequences
// (reset mid-operation, contention, wrap-around) and a randomized run
// against a transaction-scheduling reference model.
// Honours FLAG_PATTERN_DEFAULT_EN in its expectations.
module tb_flag_pattern_arbiter;
  import flag_pkg::*;

  localparam int         NREQ      = 4;
  localparam logic [3:0] RST_FLAGS = 4'b0000;
`ifdef FLAG_PATTERN_DEFAULT_EN
  localparam bit DEF_ON = 1'b1;
`else
  localparam bit DEF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*4-1:0] req_mask;
  logic [NREQ*4-1:0] req_value;
  logic [NREQ-1:0]   req_default_en;
  logic [NREQ-1:0]   req_default_val;
  logic [NREQ-1:0]   req_ready;
  struct_t           flags_o;
  logic              upd_valid;
  logic [1:0]        grant_id;

  int n_vec = 0;
  int n_err = 0;

  flag_pattern_arbiter #(
    .NREQ(NREQ),
    .RESET_FLAGS(RST_FLAGS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_mask       (req_mask),
    .req_value      (req_value),
    .req_default_en (req_default_en),
    .req_default_val(req_default_val),
    .req_ready      (req_ready),
    .flags_o        (flags_o),
    .upd_valid      (upd_valid),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] mask;
    logic [3:0] value;
    logic       den;
    logic       dval;
    logic [3:0] exp_def;
    logic [3:0] exp_nodef;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int id);
    return 32'(1) << id;
  endfunction

  // Assignment-pattern rule written straight from the field semantics.
  function automatic logic [3:0] model_apply(input logic [3:0] cur, input logic [3:0] m,
                                             input logic [3:0] v, input logic de, input logic dv);
    logic [3:0] r;
    for (int f = 0; f < 4; f++) begin
      if (m[f])              r[f] = v[f];
      else if (DEF_ON && de) r[f] = dv;
      else                   r[f] = cur[f];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid       = '0;
    req_mask        = '0;
    req_value       = '0;
    req_default_en  = '0;
    req_default_val = '0;
  endtask

  task automatic set_req(input int id, input logic [3:0] m, input logic [3:0] v,
                         input logic de, input logic dv);
    req_valid[id]         = 1'b1;
    req_mask[id*4 +: 4]   = m;
    req_value[id*4 +: 4]  = v;
    req_default_en[id]    = de;
    req_default_val[id]   = dv;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("reset flags", 32'(flags_o), 32'(RST_FLAGS));
    check("reset ready", 32'(req_ready), 32'd0);
    check("reset upd", 32'(upd_valid), 32'd0);
    check("reset grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
  endtask

  // Single request from IDLE: ack next cycle, new flags the cycle after.
  task automatic run_single(input string tag, input int id, input logic [3:0] m,
                            input logic [3:0] v, input logic de, input logic dv,
                            input logic [3:0] exp_flags);
    set_req(id, m, v, de, dv);
    tick();
    check({tag, " ready"}, 32'(req_ready), onehot(id));
    check({tag, " upd early"}, 32'(upd_valid), 32'd0);
    clear_inputs();
    tick();
    check({tag, " upd"}, 32'(upd_valid), 32'd1);
    check({tag, " flags"}, 32'(flags_o), 32'(exp_flags));
    check({tag, " grant_id"}, 32'(grant_id), 32'(id));
    check({tag, " ready off"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_ready_seq [8];
    logic [31:0] exp_gid_seq [8];
    logic [3:0]  exp_flag_seq [8];

    vecs[0] = '{0, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b1101, 4'b0000};
    vecs[1] = '{3, 4'b1111, 4'b1101, 1'b0, 1'b0, 4'b1101, 4'b1101};
    vecs[2] = '{1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0101};
    vecs[3] = '{1, 4'b1000, 4'b0000, 1'b1, 1'b1, 4'b0111, 4'b0101};
    vecs[4] = '{2, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0101};
    vecs[5] = '{2, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0101};
    vecs[6] = '{3, 4'b0101, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b0101};
    vecs[7] = '{0, 4'b1010, 4'b1010, 1'b1, 1'b0, 4'b1010, 4'b1111};
    vecs[8] = '{1, 4'b0011, 4'b0001, 1'b0, 1'b0, 4'b1001, 4'b1101};

    do_reset();

    // ---- table vectors, back to back ----
    for (int i = 0; i < 9; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].id, vecs[i].mask, vecs[i].value,
                 vecs[i].den, vecs[i].dval,
                 DEF_ON ? vecs[i].exp_def : vecs[i].exp_nodef);
    end

    // ---- reset during APPLY discards the latched request ----
    set_req(1, 4'b1111, 4'b0110, 1'b0, 1'b0);
    tick();
    check("midrst ready", 32'(req_ready), onehot(1));
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst flags", 32'(flags_o), 32'(RST_FLAGS));
    check("midrst ready off", 32'(req_ready), 32'd0);
    check("midrst upd", 32'(upd_valid), 32'd0);
    tick();
    check("midrst upd in reset", 32'(upd_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst upd after", 32'(upd_valid), 32'd0);
    check("midrst flags after", 32'(flags_o), 32'(RST_FLAGS));
    set_req(0, 4'b1111, 4'b1001, 1'b0, 1'b0);
    set_req(1, 4'b1111, 4'b0110, 1'b0, 1'b0);
    set_req(2, 4'b1111, 4'b0011, 1'b0, 1'b0);
    tick();
    check("midrst first grant", 32'(req_ready), onehot(0));
    clear_inputs();
    tick();
    check("midrst first upd", 32'(upd_valid), 32'd1);
    check("midrst first gid", 32'(grant_id), 32'd0);
    check("midrst first flags", 32'(flags_o), 32'h9);

    // ---- contention: 0, 1, 3 held valid ----
    do_reset();
    exp_ready_seq = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h8, 32'h0, 32'h1, 32'h0};
    exp_gid_seq   = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd3, 32'd3, 32'd0, 32'd0};
    exp_flag_seq  = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h8, 4'h8, 4'h1};
    set_req(0, 4'b1111, 4'b0001, 1'b0, 1'b0);
    set_req(1, 4'b1111, 4'b0010, 1'b0, 1'b0);
    set_req(3, 4'b1111, 4'b1000, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("contend c%0d ready", c + 1), 32'(req_ready), exp_ready_seq[c]);
      check($sformatf("contend c%0d upd", c + 1), 32'(upd_valid), 32'(c % 2));
      check($sformatf("contend c%0d gid", c + 1), 32'(grant_id), exp_gid_seq[c]);
      check($sformatf("contend c%0d flags", c + 1), 32'(flags_o), 32'(exp_flag_seq[c]));
    end
    clear_inputs();
    tick();
    check("contend drained", 32'(req_ready), 32'd0);

    // ---- wrap-around: last winner 3, then 0 and 2 compete ----
    run_single("wrap pre", 3, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h1);
    set_req(0, 4'b1111, 4'b0100, 1'b0, 1'b0);
    set_req(2, 4'b1111, 4'b0010, 1'b0, 1'b0);
    tick();
    check("wrap grant", 32'(req_ready), onehot(0));
    clear_inputs();
    tick();
    check("wrap flags", 32'(flags_o), 32'h4);

    // ---- randomized run against a transaction scheduler model ----
    do_reset();
    begin
      int         cyc;
      int         free_at;
      int         rdy_cyc;
      int         upd_cyc;
      int         win;
      int         m_last;
      logic [3:0] m_flags;
      logic [3:0] pend_flags;
      logic [1:0] m_gid;
      logic [31:0] exp_ready;
      cyc = 0; free_at = 0; rdy_cyc = -1; upd_cyc = -1; win = 0;
      m_last = NREQ - 1; m_flags = RST_FLAGS; pend_flags = RST_FLAGS; m_gid = '0;
      for (int n = 0; n < 3000; n++) begin
        if (cyc == upd_cyc) m_flags = pend_flags;
        if (cyc == rdy_cyc) m_gid = 2'(win);
        exp_ready = (cyc == rdy_cyc) ? onehot(win) : 32'd0;
        check("rand ready", 32'(req_ready), exp_ready);
        check("rand upd", 32'(upd_valid), (cyc == upd_cyc) ? 32'd1 : 32'd0);
        check("rand flags", 32'(flags_o), 32'(m_flags));
        check("rand grant_id", 32'(grant_id), 32'(m_gid));
        // Requesters: keep or drop after ack, occasionally raise new requests.
        for (int i = 0; i < NREQ; i++) begin
          if (exp_ready[i]) begin
            if ($urandom_range(1) == 0) req_valid[i] = 1'b0;
            else set_req(i, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
          end else if (!req_valid[i] && $urandom_range(3) == 0) begin
            set_req(i, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
          end
        end
        // Predict the grant made by the coming edge, if the block is free.
        if (cyc >= free_at && (|req_valid)) begin
          for (int off = 1; off <= NREQ; off++) begin
            int j;
            j = (m_last + off) % NREQ;
            if (req_valid[j]) begin
              win = j;
              break;
            end
          end
          m_last     = win;
          rdy_cyc    = cyc + 1;
          upd_cyc    = cyc + 2;
          free_at    = cyc + 2;
          pend_flags = model_apply(m_flags, req_mask[win*4 +: 4], req_value[win*4 +: 4],
                                   req_default_en[win], req_default_val[win]);
        end
        tick();
        cyc++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flag_pattern_arbiter.md
# flag_pattern_arbiter

Shares one registered four-field packed flag word (`first`, `second`, `third`, `fourth`) between `NREQ` requesters. Each request applies an assignment pattern to the word: named fields with explicit values, plus an optional default fill for every field not named. Requests are granted round-robin, and updates are applied one at a time. The block sits between control requesters and any logic that consumes the flag word.

## Interface
- `NREQ`, default 4: number of requesters. Legal range is 2 to 8.
- `RESET_FLAGS`, default 4'b0000: value of the flag word after reset.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset is asynchronous and active-low.
- `req_valid` input, `NREQ` bits: one request line per requester. Must stay high until that requester's `req_ready` pulses.
- `req_mask` input, `NREQ*4` bits: per requester, the fields named explicitly. Within each nibble, bit3 = `first` and bit0 = `fourth`.
- `req_value` input, `NREQ*4` bits: values for the named fields, same bit mapping as `req_mask`.
- `req_default_en` input, `NREQ` bits: when set, unnamed fields take the default value.
- `req_default_val` input, `NREQ` bits: the 1-bit default fill value.
- `req_ready` output, `NREQ` bits: one-hot, one-cycle acceptance pulse.
- `flags_o` output, 4 bits: the flag word, of type `struct_t`, with `first` as the MSB.
- `upd_valid` output, 1 bit: one-cycle pulse marking the cycle in which `flags_o` first shows a new value.
- `grant_id` output, `$clog2(NREQ)` bits: index of the requester whose update is reflected by the current `upd_valid` pulse.

## Operation
- FSM states: `IDLE`, `APPLY`.
- **`IDLE`**
  - If any `req_valid` is high, the round-robin arbiter picks a winner.
  - The winner's mask, value, `default_en` and `default_val` are latched into hold registers, and `grant_id` is latched.
  - Next state is `APPLY`. With no request, the FSM stays in `IDLE`.
- **`APPLY`**
  - `req_ready[winner]` is high for this single cycle.
  - At the end of the cycle, `flags_o` is updated and the FSM returns to `IDLE`.
- **Per-field update rule** for each field i:
  - if `mask[i]`, the new value is `value[i]`;
  - else if `default_en`, the new value is `default_val`;
  - else the field keeps its current value.
- **Round-robin pointer**
  - Holds the index of the last winner. The search starts at `last+1` and wraps modulo `NREQ`.
  - Reset value is `NREQ-1`, so requester 0 has priority first.
- A requester still holding `req_valid` after its ready pulse is treated as a new request. It competes again in the following `IDLE` cycle with the lowest priority.
- Requests arriving while the FSM is in `APPLY` are not sampled until `IDLE`.
- **Reset values:**
  - `flags_o` = `RESET_FLAGS`
  - `req_ready` = 0
  - `upd_valid` = 0
  - `grant_id` = 0
  - FSM state = `IDLE`
  - round-robin pointer = `NREQ-1`
- **Reset mid-operation:** a latched but unapplied request is discarded. No `req_ready` or `upd_valid` is produced for it, and the requester must re-request.
- **Empty mask with `default_en` = 0:** this is legal. The request is granted and acknowledged, `flags_o` is unchanged, and `upd_valid` still pulses.

## Timing
- Request is sampled in `IDLE` at edge N.
- `req_ready` is high in cycle N+1.
- `flags_o` holds the new value from edge N+2 onward, with `upd_valid` high during cycle N+2.
- Latency from sampled request to new flags is 2 cycles. Maximum throughput is one update per 2 cycles.
- Under continuous contention, each requester is served at least once every `2*NREQ` cycles.
- `upd_valid` at N+2 coincides with the next `IDLE` cycle, so the next winner's `req_ready` appears at N+3.

## Configuration
- Macro: `FLAG_PATTERN_DEFAULT_EN`.
- **Defined:** default-fill semantics apply exactly as described in Operation.
- **Undefined:** `req_default_en` and `req_default_val` are ignored (ports remain, inputs unused). Unnamed fields always hold their value, and the default hold registers are not instantiated.

## Structure
- Shared package `flag_pkg` contains:
  - `struct_t`, the packed struct with fields `first`, `second`, `third`, `fourth`;
  - field index localparams `FIRST_IDX` = 3 through `FOURTH_IDX` = 0;
  - the state enum `state_t` (`IDLE`, `APPLY`).
- Sub-module `rr_arbiter`:
  - parameterised by `NREQ`;
  - inputs: request vector and the advance strobe;
  - outputs: one-hot grant and grant index;
  - holds the round-robin pointer.

## Test plan
- **Reset:** `RESET_FLAGS` = 4'b0000, single requester 0 with mask 4'b0010, value 0, `default_en` = 1, `default_val` = 1 → `flags_o` = 4'b1101 at N+2, `upd_valid` pulses once, `grant_id` = 0.
- **Default disabled / hold:** from flags 4'b1101, requester 1 with mask 4'b1000, value 0, `default_en` = 0 → `flags_o` = 4'b0101, and with the macro undefined the same result even if `default_en` = 1.
- **Contention:** requesters 0, 1 and 3 all held valid → `req_ready` order 0, 1, 3, 0, with `upd_valid` every 2 cycles and `grant_id` matching.
- **Reset mid-operation:** assert `rst_n` low during `APPLY` → `flags_o` = `RESET_FLAGS`, no `upd_valid`. After release, requester 0 is granted first.
- **Empty update:** mask 0, `default_en` = 0 → `req_ready` pulses, `flags_o` is unchanged, `upd_valid` pulses.
- **Wrap-around:** `NREQ` = 4, last winner 3, requesters 0 and 2 valid → requester 0 is granted.
